// File: rtl/btb_pkg.sv
// Shared types and elaboration-time helpers for the set-associative branch target buffer.
package btb_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam int CTR_W = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic int tag_width(input int xlen, input int num_sets);
        return xlen - clog2(num_sets) - 2;
    endfunction

    function automatic bit geometry_ok(input int num_sets, input int num_ways, input int xlen);
        return is_pow2(num_sets) && (num_sets >= 2) &&
               is_pow2(num_ways) && (num_ways >= 1) && (num_ways <= 8) &&
               (tag_width(xlen, num_sets) >= 1);
    endfunction

    // Saturating 2-bit direction counter step.
    function automatic ctr_e ctr_train(input ctr_e ctr, input logic taken);
        ctr_e result;
        case (ctr)
            CTR_SNT: result = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: result = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  result = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  result = taken ? CTR_ST  : CTR_WT;
            default: result = CTR_SNT;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/btb_plru.sv
// Tree pseudo-LRU for one set: walks the heap-ordered node bits to find the victim and
// produces the bits after touching a way (each node on its path points away from it).
module btb_plru
    import btb_pkg::*;
#(
    parameter int NUM_WAYS = 2,
    parameter int PLRU_W   = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1,
    parameter int WAY_BITS = (NUM_WAYS > 1) ? clog2(NUM_WAYS) : 1
) (
    input  logic [PLRU_W-1:0]   bits_i,
    input  logic [WAY_BITS-1:0] touch_way_i,
    input  logic                touch_en_i,
    output logic [PLRU_W-1:0]   bits_o,
    output logic [WAY_BITS-1:0] victim_o
);

    localparam int LEVELS = clog2(NUM_WAYS);

    // Node bit 0 sends the victim search left (lower ways), 1 sends it right.
    always_comb begin : p_victim
        int node;
        node     = 0;
        victim_o = '0;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            victim_o[LEVELS-1-lvl] = bits_i[node];
            node = 2 * node + 1 + int'(bits_i[node]);
        end
    end

    // Touch: flip every node on the path so it points at the other subtree.
    always_comb begin : p_touch
        int            node;
        logic          dir;
        logic [PLRU_W-1:0] touched;
        node    = 0;
        dir     = 1'b0;
        touched = bits_i;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            dir           = touch_way_i[LEVELS-1-lvl];
            touched[node] = ~dir;
            node = 2 * node + 1 + int'(dir);
        end
        bits_o = touch_en_i ? touched : bits_i;
    end

endmodule

// File: rtl/btb_assoc.sv
// N-way set-associative BTB: registered lookup in IF2, trained from resolve, single-cycle flush.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 2,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lu_valid,
    input  logic [XLEN-1:0] lu_pc,
    input  logic            lu_stall,
    output logic            hit,
    output logic            is_branch,
    output logic            is_jump,
    output logic            pred_taken,
    output logic [XLEN-1:0] target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_is_branch,
    input  logic            upd_taken,
    input  logic            flush
);

    localparam int SET_BITS = clog2(NUM_SETS);
    localparam int TAG_W    = tag_width(XLEN, NUM_SETS);
    localparam int WAY_BITS = (NUM_WAYS > 1) ? clog2(NUM_WAYS) : 1;
    localparam int PLRU_W   = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

    if (!geometry_ok(NUM_SETS, NUM_WAYS, XLEN)) begin : g_bad_geometry
        $error("btb_assoc: illegal NUM_SETS/NUM_WAYS/XLEN combination");
    end

    logic              ent_valid_q  [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]  ent_tag_q    [NUM_SETS][NUM_WAYS];
    logic [XLEN-1:0]   ent_target_q [NUM_SETS][NUM_WAYS];
    logic              ent_is_br_q  [NUM_SETS][NUM_WAYS];
    ctr_e              ent_ctr_q    [NUM_SETS][NUM_WAYS];
    logic [PLRU_W-1:0] plru_q       [NUM_SETS];

    logic            out_hit_q, out_hit_d;
    logic            out_br_q, out_br_d;
    logic            out_jmp_q, out_jmp_d;
    logic            out_pred_q, out_pred_d;
    logic [XLEN-1:0] out_target_q, out_target_d;

    function automatic logic [WAY_BITS-1:0] first_one(input logic [NUM_WAYS-1:0] vec);
        logic [WAY_BITS-1:0] way;
        way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (vec[w]) begin
                way = WAY_BITS'(w);
            end
        end
        return way;
    endfunction

    logic [SET_BITS-1:0] lu_set_s, upd_set_s;
    logic [TAG_W-1:0]    lu_tag_s, upd_tag_s;
    logic                unused_pc_s;

    assign lu_set_s    = lu_pc[SET_BITS+1:2];
    assign lu_tag_s    = lu_pc[XLEN-1:SET_BITS+2];
    assign upd_set_s   = upd_pc[SET_BITS+1:2];
    assign upd_tag_s   = upd_pc[XLEN-1:SET_BITS+2];
    assign unused_pc_s = ^{lu_pc[1:0], upd_pc[1:0]};

    logic [NUM_WAYS-1:0] lu_match_s, upd_match_s, upd_invalid_s;
    logic                lu_hit_s, upd_hit_s, upd_any_inv_s;
    logic [WAY_BITS-1:0] lu_way_s, upd_hit_way_s, upd_inv_way_s, upd_victim_s, upd_way_s;

    // Per-way tag compare for both the lookup and the update port.
    always_comb begin
        lu_match_s    = '0;
        upd_match_s   = '0;
        upd_invalid_s = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            lu_match_s[w]    = ent_valid_q[lu_set_s][w] && (ent_tag_q[lu_set_s][w] == lu_tag_s);
            upd_match_s[w]   = ent_valid_q[upd_set_s][w] && (ent_tag_q[upd_set_s][w] == upd_tag_s);
            upd_invalid_s[w] = ~ent_valid_q[upd_set_s][w];
        end
    end

    assign lu_hit_s      = |lu_match_s;
    assign lu_way_s      = first_one(lu_match_s);
    assign upd_hit_s     = |upd_match_s;
    assign upd_hit_way_s = first_one(upd_match_s);
    assign upd_any_inv_s = |upd_invalid_s;
    assign upd_inv_way_s = first_one(upd_invalid_s);

    logic upd_write_s, lu_touch_s;
    ctr_e upd_ctr_s;

    // Not-taken misses never allocate; flush swallows the update entirely.
    assign upd_write_s = upd_valid && !flush && (upd_hit_s || upd_taken);
    assign lu_touch_s  = lu_valid && !lu_stall && !flush && lu_hit_s;

    // Way selection and counter value for the update write.
    always_comb begin
        upd_way_s = upd_hit_way_s;
        upd_ctr_s = CTR_ST;
        if (upd_hit_s) begin
            upd_way_s = upd_hit_way_s;
        end else if (upd_any_inv_s) begin
            upd_way_s = upd_inv_way_s;
        end else begin
            upd_way_s = upd_victim_s;
        end
        if (!upd_is_branch) begin
            upd_ctr_s = CTR_ST;
        end else if (upd_hit_s) begin
            upd_ctr_s = ctr_train(ent_ctr_q[upd_set_s][upd_hit_way_s], upd_taken);
        end else begin
            upd_ctr_s = CTR_WT;
        end
    end

    logic [PLRU_W-1:0]   lu_plru_next_s, upd_plru_next_s;
    logic [WAY_BITS-1:0] lu_victim_unused_s;

    btb_plru #(.NUM_WAYS(NUM_WAYS)) u_plru_lookup (
        .bits_i      (plru_q[lu_set_s]),
        .touch_way_i (lu_way_s),
        .touch_en_i  (1'b1),
        .bits_o      (lu_plru_next_s),
        .victim_o    (lu_victim_unused_s)
    );

    btb_plru #(.NUM_WAYS(NUM_WAYS)) u_plru_update (
        .bits_i      (plru_q[upd_set_s]),
        .touch_way_i (upd_way_s),
        .touch_en_i  (1'b1),
        .bits_o      (upd_plru_next_s),
        .victim_o    (upd_victim_s)
    );

    // PLRU state; the update write comes last so it wins on a shared set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                plru_q[s] <= '0;
            end
        end else if (flush) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                plru_q[s] <= '0;
            end
        end else begin
            if (lu_touch_s) begin
                plru_q[lu_set_s] <= lu_plru_next_s;
            end
            if (upd_write_s) begin
                plru_q[upd_set_s] <= upd_plru_next_s;
            end
        end
    end

    // Entry storage: flush drops valid bits only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    ent_valid_q[s][w]  <= 1'b0;
                    ent_tag_q[s][w]    <= '0;
                    ent_target_q[s][w] <= '0;
                    ent_is_br_q[s][w]  <= 1'b0;
                    ent_ctr_q[s][w]    <= CTR_SNT;
                end
            end
        end else if (flush) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    ent_valid_q[s][w] <= 1'b0;
                end
            end
        end else if (upd_write_s) begin
            ent_valid_q[upd_set_s][upd_way_s]  <= 1'b1;
            ent_tag_q[upd_set_s][upd_way_s]    <= upd_tag_s;
            ent_target_q[upd_set_s][upd_way_s] <= upd_target;
            ent_is_br_q[upd_set_s][upd_way_s]  <= upd_is_branch;
            ent_ctr_q[upd_set_s][upd_way_s]    <= upd_ctr_s;
        end
    end

    // Prediction formed from pre-update contents (no write bypass).
    always_comb begin
        logic rd_br;
        logic rd_ctr_msb;
        rd_br        = ent_is_br_q[lu_set_s][lu_way_s];
        rd_ctr_msb   = ent_ctr_q[lu_set_s][lu_way_s][1];
        out_hit_d    = lu_valid && lu_hit_s;
        out_br_d     = out_hit_d && rd_br;
        out_jmp_d    = out_hit_d && !rd_br;
        out_pred_d   = out_hit_d && (!rd_br || rd_ctr_msb);
        out_target_d = out_hit_d ? ent_target_q[lu_set_s][lu_way_s] : {XLEN{1'b0}};
    end

    // Output register: flush forces a miss even while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_hit_q    <= 1'b0;
            out_br_q     <= 1'b0;
            out_jmp_q    <= 1'b0;
            out_pred_q   <= 1'b0;
            out_target_q <= '0;
        end else if (flush) begin
            out_hit_q    <= 1'b0;
            out_br_q     <= 1'b0;
            out_jmp_q    <= 1'b0;
            out_pred_q   <= 1'b0;
            out_target_q <= '0;
        end else if (!lu_stall) begin
            out_hit_q    <= out_hit_d;
            out_br_q     <= out_br_d;
            out_jmp_q    <= out_jmp_d;
            out_pred_q   <= out_pred_d;
            out_target_q <= out_target_d;
        end
    end

    assign hit        = out_hit_q;
    assign is_branch  = out_br_q;
    assign is_jump    = out_jmp_q;
    assign pred_taken = out_pred_q;
    assign target     = out_target_q;

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc at default geometry (16 sets, 2 ways, 32-bit PC).
module tb_btb_assoc;

    logic        clk;
    logic        rst_n;
    logic        lu_valid;
    logic [31:0] lu_pc;
    logic        lu_stall;
    logic        hit;
    logic        is_branch;
    logic        is_jump;
    logic        pred_taken;
    logic [31:0] target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_is_branch;
    logic        upd_taken;
    logic        flush;

    int checks = 0;
    int errors = 0;

    btb_assoc #(.NUM_SETS(16), .NUM_WAYS(2), .XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lu_valid      (lu_valid),
        .lu_pc         (lu_pc),
        .lu_stall      (lu_stall),
        .hit           (hit),
        .is_branch     (is_branch),
        .is_jump       (is_jump),
        .pred_taken    (pred_taken),
        .target        (target),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_target    (upd_target),
        .upd_is_branch (upd_is_branch),
        .upd_taken     (upd_taken),
        .flush         (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lu_valid = 1'b0; lu_pc = 32'h0; lu_stall = 1'b0;
        upd_valid = 1'b0; upd_pc = 32'h0; upd_target = 32'h0;
        upd_is_branch = 1'b0; upd_taken = 1'b0; flush = 1'b0;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt, input logic br, input logic tk);
        upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_is_branch = br; upd_taken = tk;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic do_lookup(input logic [31:0] pc);
        lu_valid = 1'b1; lu_pc = pc;
        tick();
        lu_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick(); tick();
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b expected 0", hit); end
        checks++; if (target !== 32'h0) begin errors++; $display("FAIL reset_target: got %h expected 0", target); end
        checks++; if ({is_branch, is_jump, pred_taken} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {is_branch, is_jump, pred_taken}); end
        rst_n = 1'b1;
        tick();
        do_lookup(32'h100);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL cold_hit: got %b expected 0", hit); end
        checks++; if (target !== 32'h0) begin errors++; $display("FAIL cold_target: got %h expected 0", target); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL cold_pred: got %b expected 0", pred_taken); end
    endtask

    task automatic test_branch_counter();
        do_update(32'h100, 32'h200, 1'b1, 1'b1);   // allocate, ctr=10
        do_lookup(32'h100);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL br_alloc_hit: got %b expected 1", hit); end
        checks++; if ({is_branch, is_jump} !== 2'b10) begin errors++; $display("FAIL br_alloc_kind: got %b expected 10", {is_branch, is_jump}); end
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL br_alloc_pred: got %b expected 1", pred_taken); end
        checks++; if (target !== 32'h200) begin errors++; $display("FAIL br_alloc_target: got %h expected 00000200", target); end
        do_update(32'h100, 32'h200, 1'b1, 1'b0);   // 10 -> 01
        do_lookup(32'h100);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL br_nt1_pred: got %b expected 0", pred_taken); end
        do_update(32'h100, 32'h200, 1'b1, 1'b0);   // 01 -> 00
        do_update(32'h100, 32'h200, 1'b1, 1'b0);   // 00 holds
        do_update(32'h100, 32'h200, 1'b1, 1'b1);   // 00 -> 01
        do_lookup(32'h100);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL br_sat_low_pred: got %b expected 0", pred_taken); end
        do_update(32'h100, 32'h200, 1'b1, 1'b1);   // 01 -> 10
        do_lookup(32'h100);
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL br_recover_pred: got %b expected 1", pred_taken); end
    endtask

    task automatic test_jump_update();
        do_update(32'h100, 32'h300, 1'b0, 1'b1);   // in-place, ctr=11
        do_lookup(32'h100);
        checks++; if ({hit, is_branch, is_jump} !== 3'b101) begin errors++; $display("FAIL jmp_kind: got %b expected 101", {hit, is_branch, is_jump}); end
        checks++; if (target !== 32'h300) begin errors++; $display("FAIL jmp_target: got %h expected 00000300", target); end
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL jmp_pred: got %b expected 1", pred_taken); end
        do_update(32'h100, 32'h300, 1'b1, 1'b0);   // back to branch, 11 -> 10
        do_lookup(32'h100);
        checks++; if ({is_branch, pred_taken} !== 2'b11) begin errors++; $display("FAIL jmp_ctr_st: got %b expected 11", {is_branch, pred_taken}); end
    endtask

    task automatic test_plru();
        do_update(32'h108, 32'hA00, 1'b1, 1'b1);   // set 2 way 0
        do_update(32'h148, 32'hB00, 1'b1, 1'b1);   // set 2 way 1
        do_lookup(32'h108);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL plru_touch_hit: got %b expected 1", hit); end
        do_update(32'h188, 32'hC00, 1'b1, 1'b1);   // evicts 0x148
        do_lookup(32'h108);
        checks++; if ({hit, target} !== {1'b1, 32'hA00}) begin errors++; $display("FAIL plru_keep_108: got %b/%h expected 1/00000a00", hit, target); end
        do_lookup(32'h188);
        checks++; if ({hit, target} !== {1'b1, 32'hC00}) begin errors++; $display("FAIL plru_new_188: got %b/%h expected 1/00000c00", hit, target); end
        do_lookup(32'h148);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL plru_evict_148: got %b expected 0", hit); end
    endtask

    task automatic test_no_alloc_and_bypass();
        do_update(32'h500, 32'h600, 1'b1, 1'b0);   // not-taken miss: dropped
        do_lookup(32'h500);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL nt_miss_noalloc: got %b expected 0", hit); end
        lu_valid = 1'b1; lu_pc = 32'h500;
        upd_valid = 1'b1; upd_pc = 32'h500; upd_target = 32'h600; upd_is_branch = 1'b1; upd_taken = 1'b1;
        tick();
        lu_valid = 1'b0; upd_valid = 1'b0;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL same_cycle_alloc_old: got %b expected 0", hit); end
        do_lookup(32'h500);
        checks++; if ({hit, target} !== {1'b1, 32'h600}) begin errors++; $display("FAIL same_cycle_alloc_new: got %b/%h expected 1/00000600", hit, target); end
        lu_valid = 1'b1; lu_pc = 32'h108;
        upd_valid = 1'b1; upd_pc = 32'h108; upd_target = 32'hD00; upd_is_branch = 1'b1; upd_taken = 1'b1;
        tick();
        lu_valid = 1'b0; upd_valid = 1'b0;
        checks++; if (target !== 32'hA00) begin errors++; $display("FAIL same_cycle_upd_old: got %h expected 00000a00", target); end
        do_lookup(32'h108);
        checks++; if (target !== 32'hD00) begin errors++; $display("FAIL same_cycle_upd_new: got %h expected 00000d00", target); end
    endtask

    task automatic test_stall();
        do_lookup(32'h100);
        lu_stall = 1'b1; lu_valid = 1'b1; lu_pc = 32'h500;
        tick();
        checks++; if ({hit, target} !== {1'b1, 32'h300}) begin errors++; $display("FAIL stall_hold: got %b/%h expected 1/00000300", hit, target); end
        lu_valid = 1'b0;
        tick();
        checks++; if ({hit, is_branch, pred_taken} !== 3'b111) begin errors++; $display("FAIL stall_hold_idle: got %b expected 111", {hit, is_branch, pred_taken}); end
        lu_stall = 1'b0;
    endtask

    task automatic test_flush();
        flush = 1'b1; lu_stall = 1'b1; lu_valid = 1'b1; lu_pc = 32'h100;
        upd_valid = 1'b1; upd_pc = 32'h700; upd_target = 32'h900; upd_is_branch = 1'b0; upd_taken = 1'b1;
        tick();
        idle_inputs();
        checks++; if ({hit, target} !== {1'b0, 32'h0}) begin errors++; $display("FAIL flush_out: got %b/%h expected 0/00000000", hit, target); end
        do_lookup(32'h100);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL flush_100: got %b expected 0", hit); end
        do_lookup(32'h108);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL flush_108: got %b expected 0", hit); end
        do_lookup(32'h700);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL flush_upd_dropped: got %b expected 0", hit); end
    endtask

    task automatic test_async_reset();
        do_update(32'h100, 32'h300, 1'b0, 1'b1);
        do_lookup(32'h100);
        checks++; if ({hit, is_jump, target} !== {1'b1, 1'b1, 32'h300}) begin errors++; $display("FAIL rearm_hit: got %b/%b/%h expected 1/1/00000300", hit, is_jump, target); end
        lu_stall = 1'b1; lu_valid = 1'b1; lu_pc = 32'h100;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({hit, is_jump, pred_taken, target} !== {3'b000, 32'h0}) begin errors++; $display("FAIL async_rst_out: got %b/%h expected 000/00000000", {hit, is_jump, pred_taken}, target); end
        #1 rst_n = 1'b1;
        idle_inputs();
        tick();
        do_lookup(32'h100);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL async_rst_entries: got %b expected 0", hit); end
    endtask

    initial begin
        test_reset();
        test_branch_counter();
        test_jump_update();
        test_plru();
        test_no_alloc_and_bypass();
        test_stall();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
